// File: rtl/axis_rr_arbiter_if.sv
// Handshake bundle for the round-robin stream merger.
// slave = the arbiter's view; master = the producer/consumer environment.
interface axis_rr_arbiter_if #(
    parameter int WIDTH      = 8,
    parameter int PORTS      = 4,
    parameter int CHAN_WIDTH = $clog2(PORTS)
);
    logic [PORTS*WIDTH-1:0] idata;
    logic [PORTS-1:0]       ivalid;
    logic [PORTS-1:0]       ilast;
    logic [PORTS-1:0]       iready;
    logic [WIDTH-1:0]       odata;
    logic                   olast;
    logic [CHAN_WIDTH-1:0]  ochan;
    logic                   ovalid;
    logic                   oready;

    modport slave (
        input  idata, ivalid, ilast, oready,
        output iready, odata, olast, ochan, ovalid
    );

    modport master (
        output idata, ivalid, ilast, oready,
        input  iready, odata, olast, ochan, ovalid
    );
endinterface

// File: rtl/axis_rr_arbiter.sv
// Packet-aware round-robin merge of PORTS streams into one registered stream.
// A grant is held from the first beat of a packet through its ilast beat.
module axis_rr_arbiter #(
    parameter int WIDTH      = 8,
    parameter int PORTS      = 4,
    parameter int CHAN_WIDTH = $clog2(PORTS)
) (
    input logic              clock,
    input logic              reset,
    axis_rr_arbiter_if.slave bus
);
    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                state, state_n;
    logic [CHAN_WIDTH-1:0] ptr, ptr_n;
    logic [CHAN_WIDTH-1:0] sel, sel_n;

    logic [WIDTH-1:0]      data_q;
    logic                  last_q;
    logic [CHAN_WIDTH-1:0] chan_q;
    logic                  valid_q;

    logic [CHAN_WIDTH-1:0] win;
    logic                  win_any;
    logic [CHAN_WIDTH-1:0] grant;
    logic                  grant_ok;
    logic                  outfree;
    logic                  take;
    logic                  glast;
    logic [WIDTH-1:0]      gdata;
    logic [CHAN_WIDTH-1:0] grant_nxt;

    // Descending scan so the lowest rotated offset from ptr wins.
    always_comb begin
        int s;
        win     = '0;
        win_any = 1'b0;
        for (int k = PORTS - 1; k >= 0; k--) begin
            s = int'(ptr) + k;
            if (s >= PORTS) s = s - PORTS;
            if (bus.ivalid[CHAN_WIDTH'(s)]) begin
                win     = CHAN_WIDTH'(s);
                win_any = 1'b1;
            end
        end
    end

    assign grant     = (state == LOCKED) ? sel : win;
    assign grant_ok  = (state == LOCKED) || win_any;
    assign outfree   = !valid_q || bus.oready;
    assign take      = grant_ok && outfree && bus.ivalid[grant];
    assign glast     = bus.ilast[grant];
    assign gdata     = bus.idata[int'(grant)*WIDTH +: WIDTH];
    assign grant_nxt = (grant == CHAN_WIDTH'(PORTS - 1)) ? '0 : grant + 1'b1;

    always_comb begin
        bus.iready = '0;
        if (grant_ok) bus.iready[grant] = outfree;
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        sel_n   = sel;
        if (take) begin
            if (glast) begin
                state_n = IDLE;
                ptr_n   = grant_nxt;
            end else begin
                state_n = LOCKED;
                sel_n   = grant;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            ptr   <= '0;
            sel   <= '0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            sel   <= sel_n;
        end
    end

    // Output stage: a new beat may load in the same cycle the old one drains.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            chan_q  <= '0;
        end else if (take) begin
            valid_q <= 1'b1;
            data_q  <= gdata;
            last_q  <= glast;
            chan_q  <= grant;
        end else if (bus.oready) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.odata  = data_q;
    assign bus.olast  = last_q;
    assign bus.ochan  = chan_q;
    assign bus.ovalid = valid_q;
endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Randomized and directed checks of axis_rr_arbiter against a packet-level
// reference model (owner/pointer bookkeeping plus one output slot).
module tb_axis_rr_arbiter;
    localparam int W  = 8;
    localparam int P  = 4;
    localparam int CW = 2;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    axis_rr_arbiter_if #(.WIDTH(W), .PORTS(P), .CHAN_WIDTH(CW)) bus ();

    axis_rr_arbiter #(.WIDTH(W), .PORTS(P), .CHAN_WIDTH(CW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    // reference model
    int         m_owner;   // -1 when no packet is in flight
    int         m_ptr;
    logic       m_ovalid;
    logic [W-1:0] m_odata;
    logic       m_olast;
    int         m_ochan;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input logic [P-1:0] v);
        if (m_owner >= 0) return m_owner;
        for (int k = 0; k < P; k++)
            if (v[(m_ptr + k) % P]) return (m_ptr + k) % P;
        return -1;
    endfunction

    task automatic model_reset();
        m_owner  = -1;
        m_ptr    = 0;
        m_ovalid = 1'b0;
        m_odata  = '0;
        m_olast  = 1'b0;
        m_ochan  = 0;
    endtask

    // One clock: drive, check combinational ready, clock, check registered output.
    task automatic step(input logic [P-1:0] v, input logic [P-1:0] l,
                        input logic [P*W-1:0] d, input logic ordy, input logic rst);
        int g;
        logic outfree;
        logic [P-1:0] exp_rdy;
        @(negedge clock);
        bus.ivalid = v;
        bus.ilast  = l;
        bus.idata  = d;
        bus.oready = ordy;
        reset      = rst;
        #1;
        g       = pick(v);
        outfree = !m_ovalid || ordy;
        exp_rdy = '0;
        if (g >= 0 && outfree) exp_rdy[g] = 1'b1;
        if (!rst) chk("iready", 32'(bus.iready), 32'(exp_rdy));
        @(posedge clock);
        if (rst) begin
            model_reset();
        end else if (g >= 0 && outfree && v[g]) begin
            m_ovalid = 1'b1;
            m_odata  = d[g*W +: W];
            m_olast  = l[g];
            m_ochan  = g;
            if (l[g]) begin
                m_owner = -1;
                m_ptr   = (g + 1) % P;
            end else begin
                m_owner = g;
            end
        end else if (ordy) begin
            m_ovalid = 1'b0;
        end
        #1;
        chk("ovalid", 32'(bus.ovalid), 32'(m_ovalid));
        if (m_ovalid || rst) begin
            chk("odata", 32'(bus.odata), 32'(m_odata));
            chk("olast", 32'(bus.olast), 32'(m_olast));
            chk("ochan", 32'(bus.ochan), 32'(m_ochan));
        end
    endtask

    function automatic logic [P*W-1:0] pack(input logic [W-1:0] a, b, c, e);
        return {e, c, b, a};
    endfunction

    initial begin
        logic [P*W-1:0] d;
        logic [P-1:0] v, l;
        model_reset();
        bus.ivalid = '0; bus.ilast = '0; bus.idata = '0; bus.oready = 1'b0;
        reset = 1'b1;

        // reset state
        step('0, '0, '0, 1'b0, 1'b1);
        chk("rst_ovalid", 32'(bus.ovalid), 32'd0);
        chk("rst_ochan", 32'(bus.ochan), 32'd0);

        // all streams single-beat: chan sequence 0,1,2,3,0,1,2,3
        for (int i = 0; i < 8; i++) begin
            step(4'b1111, 4'b1111, pack(8'h10 + 8'(i), 8'h20 + 8'(i), 8'h30 + 8'(i), 8'h40 + 8'(i)), 1'b1, 1'b0);
            chk("rr_chan", 32'(bus.ochan), 32'(i % 4));
            chk("rr_valid", 32'(bus.ovalid), 32'd1);
        end
        step('0, '0, '0, 1'b1, 1'b0);

        // stream 2 three-beat packet while 0 and 3 valid; ptr is 0 so move it to 2 first
        step(4'b0010, 4'b0010, pack(8'h00, 8'h55, 8'h00, 8'h00), 1'b1, 1'b0);
        step(4'b0100, 4'b0000, pack(8'h00, 8'h00, 8'hA0, 8'h00), 1'b1, 1'b0);
        chk("pkt_A", 32'(bus.ochan), 32'd2);
        step(4'b1101, 4'b1001, pack(8'h01, 8'h00, 8'hB0, 8'h03), 1'b1, 1'b0);
        chk("pkt_B_last", 32'(bus.olast), 32'd0);
        step(4'b1101, 4'b1101, pack(8'h01, 8'h00, 8'hC0, 8'h03), 1'b1, 1'b0);
        chk("pkt_C", 32'(bus.odata), 32'hC0);
        chk("pkt_C_last", 32'(bus.olast), 32'd1);
        step(4'b1001, 4'b1001, pack(8'h01, 8'h00, 8'h00, 8'h03), 1'b1, 1'b0);
        chk("next_s3", 32'(bus.ochan), 32'd3);
        step(4'b0001, 4'b0001, pack(8'h01, 8'h00, 8'h00, 8'h00), 1'b1, 1'b0);
        chk("next_s0", 32'(bus.ochan), 32'd0);
        step('0, '0, '0, 1'b1, 1'b0);

        // backpressure on stream 1
        for (int i = 0; i < 5; i++)
            step(4'b0010, 4'b0010, pack(8'h00, 8'h60 + 8'(i), 8'h00, 8'h00), 1'b0, 1'b0);
        chk("bp_hold", 32'(bus.odata), 32'h60);
        chk("bp_rdy", 32'(bus.iready), 32'd0);
        step('0, '0, '0, 1'b1, 1'b0);
        chk("bp_drain", 32'(bus.ovalid), 32'd0);

        // locked with gap: ptr is 2, so reset then stream 0 opens a packet
        step('0, '0, '0, 1'b0, 1'b1);
        step(4'b0011, 4'b0010, pack(8'h71, 8'h91, 8'h00, 8'h00), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(4'b0010, 4'b0010, pack(8'h00, 8'h91, 8'h00, 8'h00), 1'b1, 1'b0);
            chk("gap_rdy1", 32'(bus.iready[1]), 32'd0);
        end
        step(4'b0011, 4'b0011, pack(8'h72, 8'h91, 8'h00, 8'h00), 1'b1, 1'b0);
        chk("gap_end", 32'(bus.odata), 32'h72);
        step(4'b0010, 4'b0010, pack(8'h00, 8'h91, 8'h00, 8'h00), 1'b1, 1'b0);
        chk("gap_s1", 32'(bus.ochan), 32'd1);

        // single requester 3 with ptr at 2 -> reset to put ptr at 0
        step('0, '0, '0, 1'b0, 1'b1);
        step(4'b1000, 4'b1000, pack(8'h00, 8'h00, 8'h00, 8'h33), 1'b1, 1'b0);
        chk("single_s3", 32'(bus.ochan), 32'd3);
        step(4'b0011, 4'b0011, pack(8'h0A, 8'h1A, 8'h00, 8'h00), 1'b1, 1'b0);
        chk("wrap_s0", 32'(bus.ochan), 32'd0);

        // reset mid-packet on stream 1
        step(4'b0010, 4'b0000, pack(8'h00, 8'hE1, 8'h00, 8'h00), 1'b1, 1'b0);
        step(4'b0011, 4'b0000, pack(8'h00, 8'hE2, 8'h00, 8'h00), 1'b1, 1'b1);
        chk("mid_rst_ovalid", 32'(bus.ovalid), 32'd0);
        step(4'b0011, 4'b0011, pack(8'hF0, 8'hF1, 8'h00, 8'h00), 1'b1, 1'b0);
        chk("mid_rst_s0", 32'(bus.ochan), 32'd0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            v = 4'($urandom);
            l = 4'($urandom) | 4'($urandom);
            d = {$urandom, $urandom};
            step(v, l, d, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 99) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/axis_rr_arbiter.md
Name: axis_rr_arbiter

Overview:
- Merges PORTS independent axis input streams into one axis output stream.
- Arbitration is round-robin and packet-aware: a grant is held from the first beat to the beat with ilast set, so packets never interleave.
- The output side is registered, so it can feed axis pipes and fifos directly. It also reports the source channel of each beat.
- Typical use: sharing one downstream datapath (fifo, serializer, DMA) between several producers.

Parameters:
- WIDTH, 8, data width of each stream.
- PORTS, 4, number of input streams; must be at least 2.
- CHAN_WIDTH, $clog2(PORTS), width of the channel index; must be at least 1.

Ports:
- clock  input  1  single clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- idata  input  PORTS*WIDTH  packed input data; stream i occupies bits [i*WIDTH +: WIDTH].
- ivalid  input  PORTS  per-stream valid.
- ilast  input  PORTS  per-stream end-of-packet; tie high for single-beat packets.
- iready  output  PORTS  per-stream ready; combinational.
- odata  output  WIDTH  registered output data.
- olast  output  1  registered end-of-packet.
- ochan  output  CHAN_WIDTH  registered index of the stream that supplied odata.
- ovalid  output  1  registered output valid.
- oready  input  1  downstream ready.

Behaviour:
- Transfers and timing:
  - An input beat transfers on input i when ivalid[i] && iready[i] at a clock edge.
  - An output beat transfers when ovalid && oready at a clock edge.
  - Latency is 1 cycle: a beat accepted at edge k appears on odata/olast/ochan with ovalid=1 after edge k.
  - outfree = !ovalid || oready. Input may be accepted only when outfree is true.
  - Full throughput: one beat per cycle while oready stays high.
- Reset (reset=1 at an edge):
  - ovalid=0, odata=0, olast=0, ochan=0, state=IDLE, ptr=0.
  - Reset mid-packet drops the lock and discards the output register. The partial packet is not completed.
- State machine:
  - State IDLE, no lock. The winner w is the first index i in the order ptr, ptr+1, ..., PORTS-1, 0, ..., ptr-1 with ivalid[i]=1.
    - iready[w] = outfree. All other iready bits are 0. If no ivalid bit is set, all iready bits are 0.
  - Transfer from w with ilast[w]=0: state becomes LOCKED and sel becomes w.
  - Transfer from w with ilast[w]=1: state stays IDLE and ptr becomes (w+1) mod PORTS.
  - No transfer: state and ptr are unchanged. The winner is re-evaluated every cycle while IDLE.
  - State LOCKED: iready[sel] = outfree; all other iready bits are 0. Other streams' ivalid is ignored.
  - Transfer from sel with ilast=1: state becomes IDLE and ptr becomes (sel+1) mod PORTS.
  - Transfer from sel with ilast=0: state stays LOCKED.
  - An idle gap (ivalid[sel]=0) while LOCKED keeps the lock.
- Output register:
  - On an input transfer, load odata/olast/ochan from the granted stream and set ovalid=1.
  - Otherwise, if oready=1, clear ovalid; odata/olast/ochan hold their values.
  - Otherwise hold all output registers.
  - A simultaneous output transfer and new input transfer in the same cycle is legal and required; it gives back-to-back beats.
- Constraints:
  - iready may depend on ivalid (the IDLE winner). It never depends on oready other than through outfree.
  - ptr wraps modulo PORTS. For non-power-of-two PORTS, ptr never takes the values PORTS to 2^CHAN_WIDTH-1.
  - No combinational path from idata to odata.

Test Plan:
- Reset, then drive ivalid=4'b1111, ilast=4'b1111, oready=1 for 8 cycles: ochan sequence 0,1,2,3,0,1,2,3 with ovalid high every cycle after the first accept.
- Stream 2 sends a 3-beat packet (A,B,C, ilast on C) while streams 0 and 3 are valid: output is A,B,C all with ochan=2, olast only on C; the next grant goes to stream 3, then stream 0.
- Backpressure: hold oready=0 for 5 cycles with stream 1 valid: exactly one beat is accepted; iready[1]=0 while ovalid=1 and oready=0; odata holds; the beat transfers when oready rises.
- Locked with a gap: stream 0 sends beat 1 (ilast=0), then ivalid[0]=0 for 3 cycles while stream 1 is valid: iready[1] stays 0; stream 0 resumes with its last beat, then stream 1 is granted.
- Single requester: only stream 3 valid with ptr=0: winner is 3 immediately; after its last beat ptr=0 (wrap).
- Reset asserted mid-packet on stream 1: next cycle ovalid=0, state IDLE, ptr=0; with streams 0 and 1 valid, stream 0 is granted first.
